hazard_forward_unit: RTL and testbench

Parametrised successor to the pipeline's ALU-operand forwarding logic. It produces a forwarding-mux select per source operand (NUM_SRC operands) for the EX stage, and detects load-use hazards. On a load-use hazard it runs a small FSM that holds the ID/EX stage for a configurable number of bubble cycles. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers in the CPU datapath and also keeps saturating stall and forward performance counters.

---
 rtl/hazard_forward_unit_pkg.sv | 20 ++
 rtl/hazard_forward_unit_fwd_src_select.sv | 46 ++++
 rtl/hazard_forward_unit.sv | 153 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding slice of the LC-3b pipeline.
//   lc3b_fwd_sel  : EX-stage operand mux select (register file, MEM/WB, EX/MEM)
//   lc3b_hz_state : load-use stall FSM states
package hazard_forward_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } lc3b_fwd_sel;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_BUBBLE = 1'b1
  } lc3b_hz_state;

  // Width of the internal bubble counter; holds up to 7 bubbles.
  localparam int BCNT_W = 3;

endpackage

// File: rtl/hazard_forward_unit_fwd_src_select.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   src, src_needed                       : operand register specifier and its use flag
//   ex_mem_v/dr/dr_needed/is_load         : EX/MEM producer
//   mem_wb_v/dr/dr_needed                 : MEM/WB producer
//   sel                                   : 2-bit mux select (lc3b_fwd_sel encoding)
//   m_ex                                  : operand matches the EX/MEM destination
module fwd_src_select
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W = 3
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_needed,
  input  logic             ex_mem_v,
  input  logic [REG_W-1:0] ex_mem_dr,
  input  logic             ex_mem_dr_needed,
  input  logic             ex_mem_is_load,
  input  logic             mem_wb_v,
  input  logic [REG_W-1:0] mem_wb_dr,
  input  logic             mem_wb_dr_needed,
  output logic [1:0]       sel,
  output logic             m_ex
);

  logic        m_ex_s;
  logic        m_wb_s;
  lc3b_fwd_sel sel_s;

  // Producer matching and priority: youngest producer wins, loads in EX/MEM are not forwardable.
  always_comb begin
    m_ex_s = ex_mem_v && ex_mem_dr_needed && src_needed && (ex_mem_dr == src);
    m_wb_s = mem_wb_v && mem_wb_dr_needed && src_needed && (mem_wb_dr == src);
    if (m_ex_s && !ex_mem_is_load) begin
      sel_s = FWD_EXMEM;
    end else if (m_wb_s) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_RF;
    end
  end

  assign sel  = sel_s;
  assign m_ex = m_ex_s;

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding and load-use hazard control.
// Ports:
//   clk, reset (async, active-high), advance, flush
//   id_ex_*  : consumer in ID/EX (valid, packed source specifiers, use flags)
//   ex_mem_* : producer in EX/MEM (valid, dest, writes-dest, is-load)
//   mem_wb_* : producer in MEM/WB (valid, dest, writes-dest)
//   clear_counters : synchronous clear of both perf counters
//   fwd_sel  : per-source select, src i at [2i +: 2]
//   stall    : freeze front end / ID/EX and bubble EX/MEM
//   stall_cycles, fwd_events : saturating performance counters
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
#(
  parameter int REG_W            = 3,
  parameter int NUM_SRC          = 2,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     id_ex_v,
  input  logic [NUM_SRC*REG_W-1:0] id_ex_src,
  input  logic [NUM_SRC-1:0]       id_ex_src_needed,
  input  logic                     ex_mem_v,
  input  logic [REG_W-1:0]         ex_mem_dr,
  input  logic                     ex_mem_dr_needed,
  input  logic                     ex_mem_is_load,
  input  logic                     mem_wb_v,
  input  logic [REG_W-1:0]         mem_wb_dr,
  input  logic                     mem_wb_dr_needed,
  input  logic                     clear_counters,
  output logic [2*NUM_SRC-1:0]     fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         fwd_events
);

  // The hazard cycle in RUN is itself the first bubble, so BUBBLE covers the rest.
  localparam logic [BCNT_W-1:0] BCNT_INIT = BCNT_W'(LOAD_USE_BUBBLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  lc3b_hz_state      state_r;
  logic [BCNT_W-1:0] bcnt_r;
  logic [CNT_W-1:0]  stall_cycles_r;
  logic [CNT_W-1:0]  fwd_events_r;
  logic [NUM_SRC-1:0] m_ex_s;
  logic              hazard_s;
  logic              stall_s;
  logic              any_fwd_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_select #(.REG_W(REG_W)) u_sel (
      .src              (id_ex_src[i*REG_W +: REG_W]),
      .src_needed       (id_ex_src_needed[i]),
      .ex_mem_v         (ex_mem_v),
      .ex_mem_dr        (ex_mem_dr),
      .ex_mem_dr_needed (ex_mem_dr_needed),
      .ex_mem_is_load   (ex_mem_is_load),
      .mem_wb_v         (mem_wb_v),
      .mem_wb_dr        (mem_wb_dr),
      .mem_wb_dr_needed (mem_wb_dr_needed),
      .sel              (fwd_sel[2*i +: 2]),
      .m_ex             (m_ex_s[i])
    );
  end

  assign hazard_s  = id_ex_v && ex_mem_is_load && (|m_ex_s);
  assign any_fwd_s = |fwd_sel;

  // Stall decode; flush cancels any stall in the same cycle.
  always_comb begin
    stall_s = 1'b0;
    if (flush) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        HZ_RUN:    stall_s = hazard_s;
        HZ_BUBBLE: stall_s = 1'b1;
        default:   stall_s = 1'b0;
      endcase
    end
  end

  // Load-use FSM; only advancing cycles count as bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= HZ_RUN;
      bcnt_r  <= '0;
    end else if (flush) begin
      state_r <= HZ_RUN;
      bcnt_r  <= '0;
    end else begin
      case (state_r)
        HZ_RUN: begin
          if (hazard_s && advance && (LOAD_USE_BUBBLES > 1)) begin
            state_r <= HZ_BUBBLE;
            bcnt_r  <= BCNT_INIT;
          end else begin
            state_r <= HZ_RUN;
            bcnt_r  <= bcnt_r;
          end
        end
        HZ_BUBBLE: begin
          if (advance) begin
            if (bcnt_r == BCNT_W'(1)) begin
              state_r <= HZ_RUN;
            end else begin
              state_r <= HZ_BUBBLE;
            end
            bcnt_r <= bcnt_r - BCNT_W'(1);
          end else begin
            state_r <= state_r;
            bcnt_r  <= bcnt_r;
          end
        end
        default: begin
          state_r <= HZ_RUN;
          bcnt_r  <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_r <= '0;
      fwd_events_r   <= '0;
    end else if (clear_counters) begin
      stall_cycles_r <= '0;
      fwd_events_r   <= '0;
    end else begin
      if (stall_s && advance && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
      if (advance && id_ex_v && any_fwd_s && (fwd_events_r != CNT_MAX)) begin
        fwd_events_r <= fwd_events_r + CNT_ONE;
      end else begin
        fwd_events_r <= fwd_events_r;
      end
    end
  end

  assign stall        = stall_s;
  assign stall_cycles = stall_cycles_r;
  assign fwd_events   = fwd_events_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit. Three instances share stimulus:
//   dut_a : defaults (1 bubble, 16-bit counters)
//   dut_b : 3 bubbles per load-use hazard
//   dut_c : 4-bit counters (saturation)
// Each phase resets all instances and checks only the instance it targets.
module tb_hazard_forward_unit;

  logic       clk;
  logic       reset;
  logic       advance;
  logic       flush;
  logic       id_ex_v;
  logic [5:0] id_ex_src;
  logic [1:0] id_ex_src_needed;
  logic       ex_mem_v;
  logic [2:0] ex_mem_dr;
  logic       ex_mem_dr_needed;
  logic       ex_mem_is_load;
  logic       mem_wb_v;
  logic [2:0] mem_wb_dr;
  logic       mem_wb_dr_needed;
  logic       clear_counters;

  logic [3:0]  fwd_sel_a, fwd_sel_b, fwd_sel_c;
  logic        stall_a, stall_b, stall_c;
  logic [15:0] stall_cycles_a, fwd_events_a, stall_cycles_b, fwd_events_b;
  logic [3:0]  stall_cycles_c, fwd_events_c;

  int n_assert;
  int n_fail;

  hazard_forward_unit dut_a (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .id_ex_v(id_ex_v), .id_ex_src(id_ex_src), .id_ex_src_needed(id_ex_src_needed),
    .ex_mem_v(ex_mem_v), .ex_mem_dr(ex_mem_dr), .ex_mem_dr_needed(ex_mem_dr_needed),
    .ex_mem_is_load(ex_mem_is_load), .mem_wb_v(mem_wb_v), .mem_wb_dr(mem_wb_dr),
    .mem_wb_dr_needed(mem_wb_dr_needed), .clear_counters(clear_counters),
    .fwd_sel(fwd_sel_a), .stall(stall_a), .stall_cycles(stall_cycles_a), .fwd_events(fwd_events_a)
  );

  hazard_forward_unit #(.LOAD_USE_BUBBLES(3)) dut_b (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .id_ex_v(id_ex_v), .id_ex_src(id_ex_src), .id_ex_src_needed(id_ex_src_needed),
    .ex_mem_v(ex_mem_v), .ex_mem_dr(ex_mem_dr), .ex_mem_dr_needed(ex_mem_dr_needed),
    .ex_mem_is_load(ex_mem_is_load), .mem_wb_v(mem_wb_v), .mem_wb_dr(mem_wb_dr),
    .mem_wb_dr_needed(mem_wb_dr_needed), .clear_counters(clear_counters),
    .fwd_sel(fwd_sel_b), .stall(stall_b), .stall_cycles(stall_cycles_b), .fwd_events(fwd_events_b)
  );

  hazard_forward_unit #(.CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush),
    .id_ex_v(id_ex_v), .id_ex_src(id_ex_src), .id_ex_src_needed(id_ex_src_needed),
    .ex_mem_v(ex_mem_v), .ex_mem_dr(ex_mem_dr), .ex_mem_dr_needed(ex_mem_dr_needed),
    .ex_mem_is_load(ex_mem_is_load), .mem_wb_v(mem_wb_v), .mem_wb_dr(mem_wb_dr),
    .mem_wb_dr_needed(mem_wb_dr_needed), .clear_counters(clear_counters),
    .fwd_sel(fwd_sel_c), .stall(stall_c), .stall_cycles(stall_cycles_c), .fwd_events(fwd_events_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; returns on the falling edge so inputs can be changed safely.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    advance          = 1'b1;
    flush            = 1'b0;
    id_ex_v          = 1'b0;
    id_ex_src        = 6'd0;
    id_ex_src_needed = 2'b00;
    ex_mem_v         = 1'b0;
    ex_mem_dr        = 3'd0;
    ex_mem_dr_needed = 1'b0;
    ex_mem_is_load   = 1'b0;
    mem_wb_v         = 1'b0;
    mem_wb_dr        = 3'd0;
    mem_wb_dr_needed = 1'b0;
    clear_counters   = 1'b0;
  endtask

  // Pulse the asynchronous reset between clock edges.
  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  // LDR R2 in EX/MEM; ID/EX reads src0=R5, src1=R2.
  task automatic load_use_inputs();
    id_ex_v          = 1'b1;
    id_ex_src        = {3'd2, 3'd5};
    id_ex_src_needed = 2'b11;
    ex_mem_v         = 1'b1;
    ex_mem_dr        = 3'd2;
    ex_mem_dr_needed = 1'b1;
    ex_mem_is_load   = 1'b1;
    mem_wb_v         = 1'b0;
  endtask

  // The load has moved to MEM/WB and EX/MEM holds the injected bubble.
  task automatic post_load_inputs();
    ex_mem_v         = 1'b0;
    ex_mem_is_load   = 1'b0;
    mem_wb_v         = 1'b1;
    mem_wb_dr        = 3'd2;
    mem_wb_dr_needed = 1'b1;
  endtask

  initial begin
    logic adv_pat [5];
    n_assert = 0;
    n_fail   = 0;
    adv_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    reset    = 1'b1;
    idle_inputs();
    #1;
    chk("reset_stall", {31'd0, stall_a}, 32'd0);
    chk("reset_fwd_sel", {28'd0, fwd_sel_a}, 32'd0);
    chk("reset_stall_cycles", {16'd0, stall_cycles_a}, 32'd0);
    chk("reset_fwd_events", {16'd0, fwd_events_a}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ADD R3 in EX/MEM, both sources read R3.
    id_ex_v          = 1'b1;
    id_ex_src        = {3'd3, 3'd3};
    id_ex_src_needed = 2'b11;
    ex_mem_v         = 1'b1;
    ex_mem_dr        = 3'd3;
    ex_mem_dr_needed = 1'b1;
    #1;
    chk("alu_fwd_both", {28'd0, fwd_sel_a}, 32'h0000000a);
    chk("alu_fwd_nostall", {31'd0, stall_a}, 32'd0);
    step();
    chk("alu_fwd_events", {16'd0, fwd_events_a}, 32'd1);

    // R3 in both EX/MEM and MEM/WB; src0=R3, src1=R5.
    mem_wb_v         = 1'b1;
    mem_wb_dr        = 3'd3;
    mem_wb_dr_needed = 1'b1;
    id_ex_src        = {3'd5, 3'd3};
    #1;
    chk("youngest_wins", {28'd0, fwd_sel_a}, 32'h00000002);
    ex_mem_v = 1'b0;
    #1;
    chk("memwb_fwd", {28'd0, fwd_sel_a}, 32'h00000001);
    id_ex_src_needed = 2'b10;
    #1;
    chk("src_not_needed", {28'd0, fwd_sel_a}, 32'h00000000);

    // Single-bubble load-use on dut_a.
    mem_wb_v = 1'b0;
    load_use_inputs();
    #1;
    chk("lu1_stall", {31'd0, stall_a}, 32'd1);
    chk("lu1_no_load_fwd", {28'd0, fwd_sel_a}, 32'h00000000);
    step();
    chk("lu1_stall_cycles", {16'd0, stall_cycles_a}, 32'd1);
    post_load_inputs();
    #1;
    chk("lu1_released", {31'd0, stall_a}, 32'd0);
    chk("lu1_memwb_src1", {28'd0, fwd_sel_a}, 32'h00000004);
    step();
    chk("lu1_stall_cycles_hold", {16'd0, stall_cycles_a}, 32'd1);
    chk("lu1_fwd_events", {16'd0, fwd_events_a}, 32'd2);

    // Three bubbles with two frozen cycles inside the BUBBLE state.
    idle_inputs();
    pulse_reset();
    load_use_inputs();
    for (int i = 0; i < 5; i++) begin
      advance = adv_pat[i];
      #1;
      chk($sformatf("lu3_stall_c%0d", i), {31'd0, stall_b}, 32'd1);
      step();
      if (i == 0) post_load_inputs();
      if (i == 2) chk("lu3_frozen_count", {16'd0, stall_cycles_b}, 32'd1);
    end
    advance = 1'b1;
    #1;
    chk("lu3_released", {31'd0, stall_b}, 32'd0);
    chk("lu3_stall_cycles", {16'd0, stall_cycles_b}, 32'd3);

    // Flush during the second bubble cycle.
    idle_inputs();
    pulse_reset();
    load_use_inputs();
    #1;
    chk("flush_first_stall", {31'd0, stall_b}, 32'd1);
    step();
    post_load_inputs();
    flush = 1'b1;
    #1;
    chk("flush_same_cycle", {31'd0, stall_b}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_back_to_run", {31'd0, stall_b}, 32'd0);
    chk("flush_stall_cycles", {16'd0, stall_cycles_b}, 32'd1);

    // Reset in the middle of BUBBLE.
    idle_inputs();
    pulse_reset();
    load_use_inputs();
    step();
    post_load_inputs();
    #1;
    chk("rst_mid_in_bubble", {31'd0, stall_b}, 32'd1);
    chk("rst_mid_count_before", {16'd0, stall_cycles_b}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_stall", {31'd0, stall_b}, 32'd0);
    chk("rst_mid_stall_cycles", {16'd0, stall_cycles_b}, 32'd0);
    chk("rst_mid_fwd_events", {16'd0, fwd_events_b}, 32'd0);
    reset = 1'b0;
    step();
    #1;
    chk("rst_mid_no_residual", {31'd0, stall_b}, 32'd0);

    // Counter saturation and clear on the 4-bit instance.
    idle_inputs();
    pulse_reset();
    load_use_inputs();
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 13) chk("sat_count_14", {28'd0, stall_cycles_c}, 32'd14);
    end
    chk("sat_stall_cycles", {28'd0, stall_cycles_c}, 32'd15);
    step();
    chk("sat_holding", {28'd0, stall_cycles_c}, 32'd15);
    clear_counters = 1'b1;
    step();
    chk("clear_priority", {28'd0, stall_cycles_c}, 32'd0);
    clear_counters = 1'b0;
    step();
    chk("count_after_clear", {28'd0, stall_cycles_c}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
